// File: rtl/cond_unit.sv
// cond_unit: condition check, write gating, flag register with exception save stack.
// Define COND_UNIT_PERF_EN to build the saturating ExecCnt/SkipCnt counters.
module cond_unit #(
    parameter int STACK_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             Valid,
    input  logic             ExcEntry,
    input  logic             ExcReturn,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic             StackFull,
    output logic             StackEmpty,
    output logic             StackErr,
    output logic [CNT_W-1:0] ExecCnt,
    output logic [CNT_W-1:0] SkipCnt
);
    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    logic [3:0]    flags_q, flags_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          err_q, err_d;
    logic [3:0]    stk_q [STACK_DEPTH];
    logic          n, z, c, v, live, fire, push, pop;
    logic [IW-1:0] top;
    assign {n, z, c, v} = flags_q;
    always_comb begin
        CondEx = 1'b1;
        case (Cond)
            4'b0000: CondEx = z;
            4'b0001: CondEx = ~z;
            4'b0010: CondEx = c;
            4'b0011: CondEx = ~c;
            4'b0100: CondEx = n;
            4'b0101: CondEx = ~n;
            4'b0110: CondEx = v;
            4'b0111: CondEx = ~v;
            4'b1000: CondEx = c & ~z;
            4'b1001: CondEx = ~c | z;
            4'b1010: CondEx = n == v;
            4'b1011: CondEx = n != v;
            4'b1100: CondEx = ~z & (n == v);
            4'b1101: CondEx = z | (n != v);
            default: CondEx = 1'b1;
        endcase
    end
    assign live       = Valid & ~ExcEntry & ~ExcReturn;
    assign fire       = live & CondEx;
    assign RegWrite   = fire & RegW & ~NoWrite;
    assign MemWrite   = fire & MemW;
    assign PCSrc      = fire & PCS;
    assign StackFull  = occ_q == CW'(STACK_DEPTH);
    assign StackEmpty = occ_q == '0;
    assign push       = ExcEntry & ~ExcReturn & ~StackFull;
    assign pop        = ExcReturn & ~ExcEntry & ~StackEmpty;
    assign top        = IW'(occ_q - 1'b1);
    assign flags_d    = pop  ? stk_q[top] :
                        fire ? {FlagW[1] ? ALUFlags[3:2] : flags_q[3:2],
                                FlagW[0] ? ALUFlags[1:0] : flags_q[1:0]} : flags_q;
    assign occ_d      = push ? occ_q + 1'b1 : pop ? occ_q - 1'b1 : occ_q;
    // Simultaneous entry/return is treated as a conflict, as are overflow and underflow
    assign err_d      = err_q | (ExcEntry & ExcReturn) | (ExcEntry & StackFull) | (ExcReturn & StackEmpty);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= '0;
            occ_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            occ_q   <= occ_d;
            err_q   <= err_d;
        end
    end
    always_ff @(posedge clk) if (push) stk_q[IW'(occ_q)] <= flags_q;
    assign Flags    = flags_q;
    assign StackErr = err_q;
`ifdef COND_UNIT_PERF_EN
    logic [CNT_W-1:0] exec_q, skip_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exec_q <= '0;
            skip_q <= '0;
        end else begin
            if (fire & ~&exec_q) exec_q <= exec_q + 1'b1;
            if (live & ~CondEx & ~&skip_q) skip_q <= skip_q + 1'b1;
        end
    end
    assign ExecCnt = exec_q;
    assign SkipCnt = skip_q;
`else
    assign ExecCnt = '0;
    assign SkipCnt = '0;
`endif
endmodule
